alu_issue: RTL and testbench

- RV32I decode/issue stage that drives the datapath ALU.
- Accepts fetched instructions with the PC on a valid/ready handshake and reads the register file.
- Produces ALU select codes, operands and writeback/branch control, held in a 2-entry skid buffer.
- Issues one operation per cycle downstream on a valid/ready handshake.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_decode.sv | 140 ++++++++++++++
 rtl/alu_issue.sv | 127 ++++++++++++
 tb/tb_alu_issue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I decode/issue stage: ALU select codes, opcodes and the
// issue-entry record carried through the skid buffer.
package alu_pkg;

  localparam int unsigned XlenW = 32;
  localparam int unsigned SelW  = 4;

  localparam logic [3:0] SelAdd   = 4'b0000;
  localparam logic [3:0] SelSub   = 4'b1000;
  localparam logic [3:0] SelSll   = 4'b0001;
  localparam logic [3:0] SelLt    = 4'b0010;
  localparam logic [3:0] SelLtu   = 4'b0011;
  localparam logic [3:0] SelXor   = 4'b0100;
  localparam logic [3:0] SelSrl   = 4'b0101;
  localparam logic [3:0] SelSra   = 4'b1101;
  localparam logic [3:0] SelOr    = 4'b0110;
  localparam logic [3:0] SelAnd   = 4'b0111;
  localparam logic [3:0] SelEql   = 4'b1010;
  localparam logic [3:0] SelEqu   = 4'b1011;
  localparam logic [3:0] SelPassA = 4'b1110;
  localparam logic [3:0] SelPassB = 4'b1111;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef struct packed {
    logic [3:0]  select;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        br;
    logic        br_inv;
    logic        jump;
    logic [31:0] base;
    logic [31:0] imm;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder producing one issue entry from an instruction and its operands.
// With ALU_ILLEGAL_TRAP_EN defined, illegal encodings become a flagged ADD 0,0.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr_i,
  input  logic [31:0]  pc_i,
  input  logic [31:0]  rs1_data_i,
  input  logic [31:0]  rs2_data_i,
  output issue_entry_t entry_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] shamt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd     = instr_i[11:7];
  assign shamt  = {27'b0, instr_i[24:20]};

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};

  always_comb begin
    entry_o        = '0;
    entry_o.select = SelAdd;
    entry_o.rd     = rd;
    illegal        = 1'b0;

    case (opcode)
      OpcOp: begin
        entry_o.select = {instr_i[30], funct3};
        entry_o.a      = rs1_data_i;
        entry_o.b      = rs2_data_i;
        entry_o.rd_we  = 1'b1;
        if (instr_i[30] && (funct3 != 3'b000) && (funct3 != 3'b101)) illegal = 1'b1;
      end
      OpcOpImm: begin
        entry_o.select = {(funct3 == 3'b101) ? instr_i[30] : 1'b0, funct3};
        entry_o.a      = rs1_data_i;
        entry_o.b      = imm_i;
        entry_o.imm    = imm_i;
        entry_o.rd_we  = 1'b1;
        // Shift immediates carry only the shift amount as operand b.
        if (funct3 == 3'b001) begin
          entry_o.b = shamt;
          if (instr_i[31:25] != 7'b0000000) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          entry_o.b = shamt;
          if ((instr_i[31:25] != 7'b0000000) && (instr_i[31:25] != 7'b0100000)) illegal = 1'b1;
        end
      end
      OpcLui: begin
        entry_o.select = SelPassB;
        entry_o.b      = imm_u;
        entry_o.imm    = imm_u;
        entry_o.rd_we  = 1'b1;
      end
      OpcAuipc: begin
        entry_o.a     = pc_i;
        entry_o.b     = imm_u;
        entry_o.imm   = imm_u;
        entry_o.rd_we = 1'b1;
      end
      OpcLoad: begin
        entry_o.a     = rs1_data_i;
        entry_o.b     = imm_i;
        entry_o.imm   = imm_i;
        entry_o.rd_we = 1'b1;
      end
      OpcStore: begin
        entry_o.a   = rs1_data_i;
        entry_o.b   = imm_s;
        entry_o.imm = imm_s;
      end
      OpcJal: begin
        entry_o.a     = pc_i;
        entry_o.b     = 32'd4;
        entry_o.rd_we = 1'b1;
        entry_o.jump  = 1'b1;
        entry_o.base  = pc_i;
        entry_o.imm   = imm_j;
      end
      OpcJalr: begin
        entry_o.a     = pc_i;
        entry_o.b     = 32'd4;
        entry_o.rd_we = 1'b1;
        entry_o.jump  = 1'b1;
        entry_o.base  = rs1_data_i;
        entry_o.imm   = imm_i;
      end
      OpcBranch: begin
        entry_o.a    = rs1_data_i;
        entry_o.b    = rs2_data_i;
        entry_o.br   = 1'b1;
        entry_o.base = pc_i;
        entry_o.imm  = imm_b;
        case (funct3)
          3'b000:  entry_o.select = SelEql;
          3'b001: begin
            entry_o.select = SelEql;
            entry_o.br_inv = 1'b1;
          end
          3'b100:  entry_o.select = SelLt;
          3'b101: begin
            entry_o.select = SelLt;
            entry_o.br_inv = 1'b1;
          end
          3'b110:  entry_o.select = SelLtu;
          3'b111: begin
            entry_o.select = SelLtu;
            entry_o.br_inv = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (rd == 5'd0) entry_o.rd_we = 1'b0;
    entry_o.illegal = illegal;

`ifdef ALU_ILLEGAL_TRAP_EN
    if (illegal) begin
      entry_o         = '0;
      entry_o.select  = SelAdd;
      entry_o.illegal = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes on acceptance and holds issue entries in a 2-entry skid
// buffer (main, skid). Optional feature macro: ALU_ILLEGAL_TRAP_EN (adds out_illegal).
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_select,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_br,
  output logic             out_br_inv,
  output logic             out_jump,
  output logic [XLEN-1:0]  out_base,
  output logic [XLEN-1:0]  out_imm
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic             out_illegal
`endif
);

  issue_entry_t dec_entry;
  issue_entry_t main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         keep, push, pop;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_decode u_decode (
    .instr_i    (in_instr),
    .pc_i       (in_pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .entry_o    (dec_entry)
  );

`ifdef ALU_ILLEGAL_TRAP_EN
  assign keep = 1'b1;
`else
  // Illegal instructions complete the handshake but are never buffered.
  assign keep = ~dec_entry.illegal;
  logic unused_illegal;
  assign unused_illegal = main_q.illegal;
`endif

  assign in_ready = ~skid_vld_q;
  assign push     = in_valid & in_ready & ~flush & keep;
  assign pop      = main_vld_q & out_ready & ~flush;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      // Evaluated after pop so a simultaneous pop/push refills main directly.
      if (push) begin
        if (main_vld_d) begin
          skid_d     = dec_entry;
          skid_vld_d = 1'b1;
        end else begin
          main_d     = dec_entry;
          main_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid  = main_vld_q;
  assign out_select = main_q.select;
  assign out_a      = main_q.a;
  assign out_b      = main_q.b;
  assign out_rd     = main_q.rd;
  assign out_rd_we  = main_q.rd_we;
  assign out_br     = main_q.br;
  assign out_br_inv = main_q.br_inv;
  assign out_jump   = main_q.jump;
  assign out_base   = main_q.base;
  assign out_imm    = main_q.imm;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: hand-written expected entries are queued on acceptance and
// compared when the DUT transfers an operation.
module tb_alu_issue;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [3:0]  out_select;
  logic [31:0] out_a, out_b, out_base, out_imm;
  logic        out_rd_we, out_br, out_br_inv, out_jump;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  alu_issue u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_select (out_select),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .out_br     (out_br),
    .out_br_inv (out_br_inv),
    .out_jump   (out_jump),
    .out_base   (out_base),
    .out_imm    (out_imm)
`ifdef ALU_ILLEGAL_TRAP_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        we, br, inv, jump;
    logic [31:0] base, imm;
    logic [2:0]  care;  // {a, base, imm}
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [3:0] sel, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic we,
                              input logic br, input logic inv, input logic jump,
                              input logic [31:0] base, input logic [31:0] imm,
                              input logic [2:0] care);
    exp_t e;
    e.name = name; e.sel = sel; e.a = a; e.b = b; e.rd = rd; e.we = we; e.br = br;
    e.inv = inv; e.jump = jump; e.base = base; e.imm = imm; e.care = care; e.ill = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check_eq({mon_e.name, ".sel"}, 32'(out_select), 32'(mon_e.sel));
        if (mon_e.care[2]) check_eq({mon_e.name, ".a"}, out_a, mon_e.a);
        check_eq({mon_e.name, ".b"}, out_b, mon_e.b);
        if (mon_e.we) check_eq({mon_e.name, ".rd"}, 32'(out_rd), 32'(mon_e.rd));
        check_eq({mon_e.name, ".rd_we"}, 32'(out_rd_we), 32'(mon_e.we));
        check_eq({mon_e.name, ".br"}, 32'(out_br), 32'(mon_e.br));
        check_eq({mon_e.name, ".br_inv"}, 32'(out_br_inv), 32'(mon_e.inv));
        check_eq({mon_e.name, ".jump"}, 32'(out_jump), 32'(mon_e.jump));
        if (mon_e.care[1]) check_eq({mon_e.name, ".base"}, out_base, mon_e.base);
        if (mon_e.care[0]) check_eq({mon_e.name, ".imm"}, out_imm, mon_e.imm);
`ifdef ALU_ILLEGAL_TRAP_EN
        check_eq({mon_e.name, ".illegal"}, 32'(out_illegal), 32'(mon_e.ill));
`endif
      end
    end
  end

  // Offer one instruction until accepted; queue its expectation when it is expected to issue.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e, input bit issue);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        if (issue) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_eq({e.name, ".offer_timeout"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  exp_t e_a, e_b, e_c, e_ill;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    check_eq("rst.select", 32'(out_select), 32'd0);
    check_eq("rst.a", out_a, 32'd0);
    check_eq("rst.rd_we", 32'(out_rd_we), 32'd0);
    check_eq("rst.imm", out_imm, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    in_instr = 32'h402081B3;
    #1;
    check_eq("rs1_addr", 32'(rs1_addr), 32'd1);
    check_eq("rs2_addr", 32'(rs2_addr), 32'd2);
    offer(32'h402081B3, 32'h40, 32'd10, 32'd3,
          mk("sub", 4'b1000, 32'd10, 32'd3, 5'd3, 1, 0, 0, 0, 0, 0, 3'b100), 1);
    check_eq("sub.latency", 32'(out_valid), 32'd1);
    offer(32'h40435293, 32'h44, 32'h80000000, 32'd0,
          mk("srai", 4'b1101, 32'h80000000, 32'd4, 5'd5, 1, 0, 0, 0, 0, 0, 3'b100), 1);
    offer(32'h00435293, 32'h48, 32'h80000000, 32'd0,
          mk("srli", 4'b0101, 32'h80000000, 32'd4, 5'd5, 1, 0, 0, 0, 0, 0, 3'b100), 1);
    offer(32'h0020F463, 32'h100, 32'd5, 32'd7,
          mk("bgeu", 4'b0011, 32'd5, 32'd7, 5'd0, 0, 1, 1, 0, 32'h100, 32'd8, 3'b111), 1);
    offer(32'h010000EF, 32'h200, 32'd0, 32'd0,
          mk("jal", 4'b0000, 32'h200, 32'd4, 5'd1, 1, 0, 0, 1, 32'h200, 32'd16, 3'b111), 1);
    offer(32'h12345037, 32'h204, 32'd0, 32'd0,
          mk("lui_x0", 4'b1111, 0, 32'h12345000, 5'd0, 0, 0, 0, 0, 0, 32'h12345000, 3'b001), 1);
    offer(32'hFFF00393, 32'h208, 32'd0, 32'd0,
          mk("addi_m1", 4'b0000, 0, 32'hFFFFFFFF, 5'd7, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 3'b101), 1);
    wait_drain();

    e_ill = mk("illegal", 4'b0000, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 3'b100);
    e_ill.ill = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
    offer(32'h0000007F, 32'h300, 32'd9, 32'd9, e_ill, 1);
    wait_drain();
`else
    offer(32'h0000007F, 32'h300, 32'd9, 32'd9, e_ill, 0);
    check_eq("illegal.no_valid0", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("illegal.no_valid2", 32'(out_valid), 32'd0);
`endif

    // Back-pressure: two fill the buffer, the third waits until the sink drains.
    e_a = mk("bp_a", 4'b0000, 0, 32'd1, 5'd1, 1, 0, 0, 0, 0, 32'd1, 3'b101);
    e_b = mk("bp_b", 4'b0000, 0, 32'd2, 5'd2, 1, 0, 0, 0, 0, 32'd2, 3'b101);
    e_c = mk("bp_c", 4'b0000, 0, 32'd3, 5'd3, 1, 0, 0, 0, 0, 32'd3, 3'b101);
    out_ready = 1'b0;
    offer(32'h00100093, 32'h400, 32'd0, 32'd0, e_a, 1);
    offer(32'h00200113, 32'h404, 32'd0, 32'd0, e_b, 1);
    check_eq("bp.in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp.hold_b0", out_b, 32'd1);
    @(posedge clk);
    #1;
    check_eq("bp.hold_b1", out_b, 32'd1);
    check_eq("bp.hold_valid", 32'(out_valid), 32'd1);
    fork
      offer(32'h00300193, 32'h408, 32'd0, 32'd0, e_c, 1);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    offer(32'h00100093, 32'h500, 32'd0, 32'd0, e_a, 1);
    offer(32'h00200113, 32'h504, 32'd0, 32'd0, e_b, 1);
    in_valid = 1'b1; in_instr = 32'h00300193; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_eq("flush.out_valid", 32'(out_valid), 32'd0);
    check_eq("flush.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("flush.no_late_issue", 32'(out_valid), 32'd0);

    // Flush on an empty buffer must still reject the same-cycle input.
    in_valid = 1'b1; in_instr = 32'h00100093; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_empty.out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    offer(32'h00100093, 32'h600, 32'd0, 32'd0, e_a, 1);
    offer(32'h00200113, 32'h604, 32'd0, 32'd0, e_b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst.in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
